fp_addsub_normround: RTL and testbench

- Post-execute stage of the FP add/sub datapath. Consumes the raw 26-bit mantissa sum, result sign, larger exponent and alignment guard/sticky bits.
- Normalises (right-shift by 1 on carry, or left-shift by leading-zero count), rounds to nearest even, handles exponent overflow/underflow, and packs an IEEE-754 single-precision word.
- 3-stage pipeline with valid/ready flow control. Fed directly by the execute stage's Sum/Sgn outputs plus upstream exponent and G/S.

---
 rtl/fp_addsub_pkg.sv | 26 ++
 rtl/fp_addsub_lzc.sv | 20 ++
 rtl/fp_addsub_normround.sv | 162 ++++++++++++++++
 tb/tb_fp_addsub_normround.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_addsub_pkg.sv
// Shared constants, stage-3 payload type and flag bit positions for the FP add/sub
// normalise/round stage.
package fp_addsub_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int SUM_W   = MAN_W + 3;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_ZERO      = 1;
    localparam int FLAG_UNDERFLOW = 2;
    localparam int FLAG_OVERFLOW  = 3;

    // Exponent carries two extra bits so that underflow (<=0) and overflow (>=255) stay visible.
    typedef struct packed {
        logic                    sgn;
        logic signed [EXP_W+1:0] exp;
        logic [MAN_W:0]          man;
        logic                    r;
        logic                    st;
        logic                    iszero;
    } s3_payload_t;

endpackage

// File: rtl/fp_addsub_lzc.sv
// Combinational leading-zero counter over the 24-bit hidden+fraction field;
// returns 24 when the input is all zero.
module fp_addsub_lzc
    import fp_addsub_pkg::*;
(
    input  logic [MAN_W:0] value,
    output logic [4:0]     count
);

    // Scan upward so the highest set bit is the last (winning) assignment.
    always_comb begin
        count = 5'd24;
        for (int i = 0; i <= MAN_W; i++) begin
            if (value[i]) begin
                count = 5'(MAN_W - i);
            end
        end
    end

endmodule

// File: rtl/fp_addsub_normround.sv
// Three-stage normalise / round-to-nearest-even / pack stage for single-precision add/sub.
// Define FPADDSUB_EXC_FLAGS_EN to add the registered Flags[3:0] = {overflow, underflow, zero, inexact} port.
module fp_addsub_normround #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MAN_W+2:0]       Sum,
    input  logic                   Sgn,
    input  logic [EXP_W-1:0]       Emax,
    input  logic                   G,
    input  logic                   S,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   Result
`ifdef FPADDSUB_EXC_FLAGS_EN
    ,
    output logic [3:0]             Flags
`endif
);

    import fp_addsub_pkg::*;

    logic v1, v2, v3;
    logic en1, en2, en3;

    assign en3       = ~v3 | out_ready;
    assign en2       = ~v2 | en3;
    assign en1       = ~v1 | en2;
    assign in_ready  = en1;
    assign out_valid = v3;

    logic sum_unused;
    assign sum_unused = Sum[MAN_W+2];

    logic [4:0]         lz_in;
    logic [SUM_W-2:0]   s1_sum;
    logic [EXP_W-1:0]   s1_emax;
    logic               s1_sgn, s1_g, s1_s, s1_carry, s1_zero;
    logic [4:0]         s1_lz;

    fp_addsub_lzc u_lzc (
        .value (Sum[MAN_W:0]),
        .count (lz_in)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (en1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_sum   <= Sum[MAN_W+1:0];
                s1_sgn   <= Sgn;
                s1_emax  <= Emax;
                s1_g     <= G;
                s1_s     <= S;
                s1_carry <= Sum[MAN_W+1];
                s1_lz    <= lz_in;
                s1_zero  <= (Sum[MAN_W+1:0] == '0) & ~G & ~S;
            end
        end
    end

    logic [MAN_W+1:0] ext, shifted;
    s3_payload_t      p2_next, p2;

    // The guard bit rides along as the 25th bit so it becomes the round bit when no shift occurs.
    always_comb begin
        ext     = {s1_sum[MAN_W:0], s1_g};
        shifted = ext << s1_lz;
        p2_next        = '0;
        p2_next.sgn    = s1_sgn;
        p2_next.iszero = s1_zero;
        if (s1_carry) begin
            p2_next.man = s1_sum[MAN_W+1:1];
            p2_next.r   = s1_sum[0];
            p2_next.st  = s1_g | s1_s;
            p2_next.exp = {2'b00, s1_emax} + (EXP_W+2)'(1);
        end else begin
            p2_next.man = shifted[MAN_W+1:1];
            p2_next.r   = shifted[0];
            p2_next.st  = s1_s;
            p2_next.exp = {2'b00, s1_emax} - (EXP_W+2)'(s1_lz);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                p2 <= p2_next;
            end
        end
    end

    logic                    up, rnd_carry, hidden_unused, of, uf;
    logic [MAN_W-1:0]        rnd_frac;
    logic signed [EXP_W+1:0] exp_r;
    logic [EXP_W+MAN_W:0]    res_next;
    logic [3:0]              flg_next;

    // Mantissa overflow from rounding leaves 1.000..0, so the fraction becomes zero.
    always_comb begin
        up = p2.r & (p2.st | p2.man[0]);
        {rnd_carry, hidden_unused, rnd_frac} = {1'b0, p2.man} + (MAN_W+2)'(up);
        exp_r = p2.exp;
        if (rnd_carry) begin
            rnd_frac = '0;
            exp_r    = p2.exp + (EXP_W+2)'(1);
        end
        of       = 1'b0;
        uf       = 1'b0;
        flg_next = '0;
        if (p2.iszero) begin
            res_next            = '0;
            flg_next[FLAG_ZERO] = 1'b1;
        end else if (exp_r <= 0) begin
            uf       = 1'b1;
            res_next = {p2.sgn, (EXP_W+MAN_W)'(0)};
        end else if (exp_r >= EXP_MAX) begin
            of       = 1'b1;
            res_next = {p2.sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            res_next = {p2.sgn, exp_r[EXP_W-1:0], rnd_frac};
        end
        if (!p2.iszero) begin
            flg_next[FLAG_OVERFLOW]  = of;
            flg_next[FLAG_UNDERFLOW] = uf;
            flg_next[FLAG_INEXACT]   = p2.r | p2.st | of | uf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3     <= 1'b0;
            Result <= '0;
`ifdef FPADDSUB_EXC_FLAGS_EN
            Flags  <= '0;
`endif
        end else if (en3) begin
            v3 <= v2;
            if (v2) begin
                Result <= res_next;
`ifdef FPADDSUB_EXC_FLAGS_EN
                Flags  <= flg_next;
`endif
            end
        end
    end

`ifndef FPADDSUB_EXC_FLAGS_EN
    logic [3:0] flags_unused;
    assign flags_unused = flg_next;
`endif

endmodule

// File: tb/tb_fp_addsub_normround.sv
// Directed self-checking bench for fp_addsub_normround with a value-level rounding model
// and a scoreboard compared on every output transfer.
module tb_fp_addsub_normround;

    import fp_addsub_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, Sgn, G, S, out_valid, out_ready;
    logic [25:0] Sum;
    logic [7:0]  Emax;
    logic [31:0] Result;
`ifdef FPADDSUB_EXC_FLAGS_EN
    logic [3:0]  Flags;
`endif

    always #5 clk = ~clk;

    fp_addsub_normround dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sum       (Sum),
        .Sgn       (Sgn),
        .Emax      (Emax),
        .G         (G),
        .S         (S),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result)
`ifdef FPADDSUB_EXC_FLAGS_EN
        ,
        .Flags     (Flags)
`endif
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    typedef struct {
        logic [25:0] sum;
        logic        sgn;
        logic [7:0]  emax;
        logic        g;
        logic        s;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_in = 0;
    int          n_out = 0;
    exp_t        exp_q[$];
    bit          stall_prev = 0;
    logic [31:0] hold_res;
    vec_t        items[9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Value-level model: locate the leading one of the exact significand, keep 24 bits, round to nearest even.
    function automatic logic [35:0] model(input logic [25:0] sum, input logic sgn,
                                          input logic [7:0] emax, input logic g, input logic s);
        logic [63:0] x;
        logic [24:0] mant;
        logic        r, st, of, uf, nx;
        logic [31:0] res;
        int          p, e;
        if (sum[24:0] == 25'd0 && !g && !s) return {4'b0010, 32'h0};
        x = (64'(sum[24:0]) << 31) | (64'(g) << 30) | 64'(s);
        p = 0;
        for (int i = 0; i < 64; i++) if (x[i]) p = i;
        e    = int'(emax) + p - 54;
        mant = {1'b0, x[p -: 24]};
        r    = x[p-24];
        st   = (x & ((64'd1 << (p-24)) - 64'd1)) != 64'd0;
        if (r && (st || mant[0])) mant = mant + 25'd1;
        if (mant[24]) begin
            mant = mant >> 1;
            e++;
        end
        of = 1'b0;
        uf = 1'b0;
        if (e <= 0) begin
            uf  = 1'b1;
            res = {sgn, 31'h0};
        end else if (e >= 255) begin
            of  = 1'b1;
            res = {sgn, 8'hFF, 23'h0};
        end else begin
            res = {sgn, 8'(e), mant[22:0]};
        end
        nx = r | st | of | uf;
        return {of, uf, 1'b0, nx, res};
    endfunction

    // Single compare process: scoreboard on output transfers, hold check while stalled, capture on input transfers.
    always @(negedge clk) begin
        exp_t e;
        logic [35:0] m;
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_output", 64'(Result), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("result", 64'(Result), 64'(e.res));
`ifdef FPADDSUB_EXC_FLAGS_EN
                    checkOutput("flags", 64'(Flags), 64'(e.flg));
`endif
                end
            end
            if (stall_prev) begin
                checkOutput("stall_valid", 64'(out_valid), 64'd1);
                checkOutput("stall_result", 64'(Result), 64'(hold_res));
            end
            stall_prev = out_valid && !out_ready;
            hold_res   = Result;
            if (in_valid && in_ready) begin
                m = model(Sum, Sgn, Emax, G, S);
                e.res = m[31:0];
                e.flg = m[35:32];
                exp_q.push_back(e);
                n_in++;
            end
        end else begin
            stall_prev = 0;
        end
    end

    task automatic applyStimulus(input logic [25:0] sum, input logic sgn, input logic [7:0] emax,
                                 input logic g, input logic s, output int t_in);
        bit done;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        Sum = sum; Sgn = sgn; Emax = emax; G = g; S = s;
        done = 0;
        t_in = -1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                t_in = cyc;
            end
        end
        if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        bit done = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) done = 1;
        end
        checkOutput(name, 64'(done), 64'd1);
    endtask

    task automatic feedItems(input int first, input int count, input int stall_lo, input int stall_hi,
                             output bit saw_low);
        int idx = 0;
        saw_low = 0;
        for (int c = 0; c < 80 && idx < count; c++) begin
            @(posedge clk);
            #1;
            out_ready = !(c >= stall_lo && c < stall_hi);
            in_valid  = 1'b1;
            Sum  = items[first+idx].sum;
            Sgn  = items[first+idx].sgn;
            Emax = items[first+idx].emax;
            G    = items[first+idx].g;
            S    = items[first+idx].s;
            @(negedge clk);
            if (!in_ready) saw_low = 1;
            if (in_ready) idx++;
        end
        if (idx < count) checkOutput("feed_timeout", 64'(idx), 64'(count));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int  t_in;
        bit  saw_low, done, quiet;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        Sum = '0; Sgn = 1'b0; Emax = '0; G = 1'b0; S = 1'b0;

        items[0] = '{26'h0800000, 1'b0, 8'd100, 1'b0, 1'b0};
        items[1] = '{26'h1555555, 1'b1, 8'd130, 1'b0, 1'b0};
        items[2] = '{26'h0123456, 1'b0, 8'd120, 1'b1, 1'b1};
        items[3] = '{26'h1FFFFFF, 1'b0, 8'd127, 1'b1, 1'b0};
        items[4] = '{26'h0000F00, 1'b1, 8'd200, 1'b0, 1'b0};
        items[5] = '{26'h2ABCDEF, 1'b1, 8'd90,  1'b0, 1'b1};
        items[6] = '{26'h0C00001, 1'b0, 8'd3,   1'b1, 1'b0};
        items[7] = '{26'h1000001, 1'b0, 8'd50,  1'b0, 1'b1};
        items[8] = '{26'h0000003, 1'b1, 8'd20,  1'b0, 1'b0};

        // Hand-computed expectations pin the model; flags are {overflow, underflow, zero, inexact}.
        checkOutput("pin_one_plus_one", 64'(model(26'h1000000, 0, 127, 0, 0)), 64'({4'b0000, 32'h40000000}));
        checkOutput("pin_cancel",       64'(model(26'h0000001, 0, 127, 0, 0)), 64'({4'b0000, 32'h34000000}));
        checkOutput("pin_zero",         64'(model(26'h0000000, 1, 127, 0, 0)), 64'({4'b0010, 32'h00000000}));
        checkOutput("pin_underflow",    64'(model(26'h0400000, 0, 1,   0, 0)), 64'({4'b0101, 32'h00000000}));
        checkOutput("pin_tie_up",       64'(model(26'h0FFFFFF, 0, 127, 1, 0)), 64'({4'b0001, 32'h40000000}));
        checkOutput("pin_tie_even",     64'(model(26'h0FFFFFE, 0, 127, 1, 0)), 64'({4'b0001, 32'h3FFFFFFE}));
        checkOutput("pin_overflow",     64'(model(26'h1000000, 0, 254, 0, 0)), 64'({4'b1001, 32'h7F800000}));

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_result", 64'(Result), 64'd0);
`ifdef FPADDSUB_EXC_FLAGS_EN
        checkOutput("reset_flags", 64'(Flags), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

        applyStimulus(26'h1000000, 1'b0, 8'(BIAS), 1'b0, 1'b0, t_in);
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (out_valid) done = 1;
        end
        checkOutput("latency", 64'(cyc - t_in), 64'd3);
        waitDrain("drain_single");

        applyStimulus(26'h0000001, 1'b0, 8'd127, 1'b0, 1'b0, t_in);
        applyStimulus(26'h0000000, 1'b1, 8'd127, 1'b0, 1'b0, t_in);
        applyStimulus(26'h0400000, 1'b0, 8'd1,   1'b0, 1'b0, t_in);
        applyStimulus(26'h0FFFFFF, 1'b0, 8'd127, 1'b1, 1'b0, t_in);
        applyStimulus(26'h0FFFFFE, 1'b0, 8'd127, 1'b1, 1'b0, t_in);
        applyStimulus(26'h1000000, 1'b0, 8'd254, 1'b0, 1'b0, t_in);
        waitDrain("drain_directed");

        n_in = 0;
        n_out = 0;
        feedItems(0, 6, 2, 6, saw_low);
        waitDrain("drain_stream");
        checkOutput("stream_in_ready_dropped", 64'(saw_low), 64'd1);
        checkOutput("stream_count", 64'(n_out), 64'(n_in));
        checkOutput("stream_items", 64'(n_in), 64'd6);

        feedItems(6, 3, 100, 100, saw_low);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_flush_valid", 64'(out_valid), 64'd0);
        quiet = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) quiet = 0;
        end
        checkOutput("rst_pipe_empty", 64'(quiet), 64'd1);

        applyStimulus(items[8].sum, items[8].sgn, items[8].emax, items[8].g, items[8].s, t_in);
        waitDrain("drain_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
